// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: post-reset flush, memory-wait freeze, mispredict
// squash and load-use stall for the F/D/E/M/W pipeline registers.
// Ports:
//   clk_i, rst_i                : clock, synchronous active-high reset
//   D_rs1_i/D_rs2_i/*_used_i    : source registers read by the D instruction
//   E_opcode_i, E_rd_i          : opcode and destination of the E instruction
//   e_mispredict_i              : E resolved a redirect
//   M_mem_req_i, m_mem_ready_i  : M-stage memory access and its completion
//   *_stall_o, *_bubble_o       : per-stage pipeline register controls
//   mem_timeout_o               : sticky memory-timeout flag
// Optional macro HAZARD_PERF_CNT_EN adds perf_lu/mp/mw_cnt_o event counters.
module pipe_hazard_ctrl #(
  parameter int RST_FLUSH_CYCLES = 4,
  parameter int MEM_TIMEOUT      = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  D_rs1_i,
  input  logic [4:0]  D_rs2_i,
  input  logic        D_rs1_used_i,
  input  logic        D_rs2_used_i,
  input  logic [6:0]  E_opcode_i,
  input  logic [4:0]  E_rd_i,
  input  logic        e_mispredict_i,
  input  logic        M_mem_req_i,
  input  logic        m_mem_ready_i,
  output logic        F_stall_o,
  output logic        D_stall_o,
  output logic        D_bubble_o,
  output logic        E_stall_o,
  output logic        E_bubble_o,
  output logic        M_stall_o,
  output logic        M_bubble_o,
  output logic        W_stall_o,
  output logic        W_bubble_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] perf_lu_cnt_o,
  output logic [31:0] perf_mp_cnt_o,
  output logic [31:0] perf_mw_cnt_o,
`endif
  output logic        mem_timeout_o
);

  typedef enum logic [1:0] {
    S_FLUSH,
    S_RUN,
    S_MEM_WAIT
  } state_t;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [3:0] FLUSH_N = 4'(RST_FLUSH_CYCLES);
  localparam logic [7:0] TMO_N   = 8'(MEM_TIMEOUT);

  state_t     r_state;
  logic [3:0] r_fcnt;
  logic [7:0] r_wcnt;
  logic       r_tmo;

  logic       w_flush;
  logic       w_lu_hit;
  logic       w_mw;
  logic       w_mp;
  logic       w_lu;
  logic [7:0] w_wcnt_inc;

  // Reset overrides the outputs in the same cycle it is asserted.
  assign w_flush = rst_i | (r_state == S_FLUSH);

  assign w_lu_hit = (E_opcode_i == OP_LOAD) && (E_rd_i != 5'd0) &&
                    ((D_rs1_used_i && (D_rs1_i == E_rd_i)) ||
                     (D_rs2_used_i && (D_rs2_i == E_rd_i)));

  // Priority-resolved, mutually exclusive events.
  assign w_mw = ~w_flush & M_mem_req_i & ~m_mem_ready_i;
  assign w_mp = ~w_flush & ~w_mw & e_mispredict_i;
  assign w_lu = ~w_flush & ~w_mw & ~e_mispredict_i & w_lu_hit;

  assign w_wcnt_inc = (r_wcnt == 8'hFF) ? r_wcnt : r_wcnt + 8'd1;

  always_comb begin
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_stall_o  = 1'b0;
    E_bubble_o = 1'b0;
    M_stall_o  = 1'b0;
    M_bubble_o = 1'b0;
    W_stall_o  = 1'b0;
    W_bubble_o = 1'b0;
    unique case (1'b1)
      w_flush: begin
        D_bubble_o = 1'b1;
        E_bubble_o = 1'b1;
        M_bubble_o = 1'b1;
        W_bubble_o = 1'b1;
      end
      w_mw: begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_stall_o  = 1'b1;
        M_stall_o  = 1'b1;
        W_bubble_o = 1'b1;
      end
      w_mp: begin
        D_bubble_o = 1'b1;
        E_bubble_o = 1'b1;
      end
      w_lu: begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        E_bubble_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_timeout_o = r_tmo & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_FLUSH;
      r_fcnt  <= FLUSH_N;
      r_wcnt  <= '0;
      r_tmo   <= 1'b0;
    end else begin
      unique case (r_state)
        S_FLUSH: begin
          r_wcnt <= '0;
          if (r_fcnt <= 4'd1) begin
            r_state <= S_RUN;
          end else begin
            r_fcnt <= r_fcnt - 4'd1;
          end
        end
        S_RUN, S_MEM_WAIT: begin
          if (w_mw) begin
            r_state <= S_MEM_WAIT;
            r_wcnt  <= w_wcnt_inc;
            if (w_wcnt_inc >= TMO_N) begin
              r_tmo <= 1'b1;
            end
          end else if ((r_state == S_MEM_WAIT) && !m_mem_ready_i) begin
            // Request withdrawn without completion: keep waiting.
            r_state <= S_MEM_WAIT;
          end else begin
            r_state <= S_RUN;
            r_wcnt  <= '0;
          end
        end
        default: r_state <= S_FLUSH;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_lu_cnt;
  logic [31:0] r_mp_cnt;
  logic [31:0] r_mw_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lu_cnt <= '0;
      r_mp_cnt <= '0;
      r_mw_cnt <= '0;
    end else begin
      if (w_lu) r_lu_cnt <= r_lu_cnt + 32'd1;
      if (w_mp) r_mp_cnt <= r_mp_cnt + 32'd1;
      if (w_mw) r_mw_cnt <= r_mw_cnt + 32'd1;
    end
  end

  assign perf_lu_cnt_o = r_lu_cnt;
  assign perf_mp_cnt_o = r_mp_cnt;
  assign perf_mw_cnt_o = r_mw_cnt;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline control unit that drives the per-stage stall and bubble inputs of the F/D/E/M/W pipeline registers, including the E register's E_stall_i and E_bubble_i.
- Detects load-use hazards between the E and D stages.
- Squashes wrong-path instructions on an E-stage branch or jump mispredict.
- Freezes the pipe while the M-stage data memory is not ready.
- Sequences a post-reset flush.

Parameters:
RST_FLUSH_CYCLES, 4, number of cycles all bubbles stay asserted after rst_i deasserts (1..15)
MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_timeout_o sets (1..255)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
D_rs1_i  in  5  rs1 of instruction in D
D_rs2_i  in  5  rs2 of instruction in D
D_rs1_used_i  in  1  D instruction reads rs1
D_rs2_used_i  in  1  D instruction reads rs2
E_opcode_i  in  7  opcode in E
E_rd_i  in  5  rd in E
e_mispredict_i  in  1  E resolved a branch/jump to a PC other than E_pre_pc
M_mem_req_i  in  1  M holds a load/store
m_mem_ready_i  in  1  data memory completes this cycle
F_stall_o  out  1  hold PC register
D_stall_o, D_bubble_o  out  1 each  D register control
E_stall_o, E_bubble_o  out  1 each  E register control
M_stall_o, M_bubble_o  out  1 each  M register control
W_stall_o, W_bubble_o  out  1 each  W register control
mem_timeout_o  out  1  sticky memory-timeout error flag

Behaviour:
Interface:
- Single clock clk_i.
- Reset rst_i is synchronous and active-high.

State machine (state register plus 4-bit flush counter plus 8-bit wait counter):
- FLUSH:
  - Entered on the cycle after rst_i=1.
  - All *_bubble_o=1 and all stalls=0.
  - The counter counts from RST_FLUSH_CYCLES down to 1. On reaching 1, the next state is RUN.
- RUN: outputs are Mealy and combinational from the inputs, evaluated in the priority order below (highest first).
- MEM_WAIT:
  - Entered when M_mem_req_i=1 and m_mem_ready_i=0 in RUN.
  - Stays while m_mem_ready_i=0.
  - Returns to RUN on the cycle after m_mem_ready_i=1.

Output values during rst_i=1 (the reset values):
- All *_bubble_o=1.
- All stalls=0.
- mem_timeout_o=0, counters=0.

Priority 1, memory wait (M_mem_req_i=1 and m_mem_ready_i=0, in either RUN or MEM_WAIT):
- F, D, E, M stall=1.
- W_bubble_o=1.
- All other bubbles=0.
- Overrides everything else. Mispredict and load-use signals are frozen in place and re-evaluate once memory is ready.
- The cycle with m_mem_ready_i=1 is not a wait cycle; normal priorities apply.

Priority 2, mispredict (e_mispredict_i=1):
- D_bubble_o=1 and E_bubble_o=1.
- No stalls. F loads the redirected PC.

Priority 3, load-use:
- Condition: E_opcode_i==7'b0000011 and E_rd_i!=0, and either (D_rs1_used_i and D_rs1_i==E_rd_i) or (D_rs2_used_i and D_rs2_i==E_rd_i).
- F_stall_o=1, D_stall_o=1, E_bubble_o=1.
- Lasts exactly one cycle, because the bubble clears E.

Simultaneous events:
- Mispredict together with load-use: mispredict wins (the D instruction is wrong-path anyway).
- Rule: no stage ever has stall=1 and bubble=1 in the same cycle.

Default: all outputs 0.

Timeout:
- The wait counter increments on each MEM_WAIT cycle and saturates.
- When it reaches MEM_TIMEOUT, mem_timeout_o is set. It stays set until rst_i.
- The counter clears on leaving MEM_WAIT.
- Stalling continues after the timeout; the flag is diagnostic only.

Reset mid-operation:
- rst_i in any state forces FLUSH on the next edge.
- All outputs revert to reset values in the same cycle.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - Adds outputs perf_lu_cnt_o[31:0], perf_mp_cnt_o[31:0] and perf_mw_cnt_o[31:0].
  - These count load-use cycles, mispredict cycles and memory-wait cycles, using the priority-resolved events, in RUN/MEM_WAIT only.
  - Reset to 0; wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset flush: rst_i=1 for 2 cycles, then 0 → all bubbles=1 for 2 reset cycles plus 4 FLUSH cycles, then all outputs 0 with idle inputs.
- Load-use: E_opcode_i=0000011, E_rd_i=5, D_rs2_i=5, D_rs2_used_i=1 → F_stall_o=D_stall_o=E_bubble_o=1 for 1 cycle. Same stimulus with E_rd_i=0 → no stall.
- Mispredict: e_mispredict_i=1 for 1 cycle → D_bubble_o=E_bubble_o=1, F_stall_o=0. Adding a simultaneous load-use match produces the same outputs.
- Memory wait: M_mem_req_i=1 with m_mem_ready_i=0 for 3 cycles, then ready → F/D/E/M stall and W_bubble_o=1 for exactly 3 cycles, and e_mispredict_i=1 during the wait is ignored. The mispredict bubbles appear on the ready cycle.
- Timeout: with MEM_TIMEOUT=8, hold ready=0 for 10 cycles → mem_timeout_o rises after the 8th wait cycle and stays 1 after ready, until rst_i.
- Reset mid-wait: rst_i=1 in MEM_WAIT → stalls drop and bubbles rise in the same cycle, then a FLUSH sequence follows.
